pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined MIPS control unit: decodes the ID-stage instruction and registers the control bundle into ID/EX.
//  Detects load-use hazards (stall + bubble) and resolves branches/jumps in EX (flush + NPC select).
//  Keeps saturating stall/flush performance counters. Sits between the IF/ID register and the EX datapath.
// PARAMETERS
//  REG_AW    5   register address width
//  ALUOP_W   4   ALU operation code width; the package encodings are zero-extended to it
//  LINK_REG  31  destination register for jal
//  CNT_W     16  performance counter width
// PORTS
//  clk              in   1        clock; all state on rising edge
//  rst_n            in   1        synchronous, active-low reset
//  id_valid         in   1        IF/ID holds a valid instruction
//  id_instr         in   32       IF/ID instruction
//  ex_zero          in   1        ALU zero flag for the instruction now in EX
//  stall_o          out  1        hold PC and IF/ID this cycle (combinational)
//  flush_o          out  1        kill IF/ID this cycle; redirect taken (combinational)
//  npc_op           out  2        00 PC+4, 01 branch, 10 jump, 11 register (combinational from EX)
//  ex_valid         out  1        ID/EX holds a real instruction (0 = bubble)
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_ext_op  out 1 each  registered controls
//  ex_alu_asrc, ex_shift_idx, ex_shift_dir, ex_call  out 1 each  registered shift/link controls
//  ex_alu_op        out  ALUOP_W  ALU operation
//  ex_wr_addr       out  REG_AW   destination register: rd (R-type, jalr), rt (I-type), LINK_REG (jal)
//  ex_illegal       out  1        unrecognised opcode/funct
//  ex_mem_size      out  2        00 byte, 01 half, 10 word
//  ex_mem_unsigned  out  1        zero-extend the load result
//  stall_cnt, flush_cnt  out  CNT_W  saturating event counters
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): every registered output and both counters become 0.
//    stall_o, flush_o and npc_op are then 0, because they depend only on ex_valid=0.
//  - Latency: 1 cycle. A decode of id_instr appears on ex_* at the next edge.
//  - Supported set: add, addu, sub, subu, and, or, nor, slt, sltu, sll, sllv, srl, srlv, jr, jalr,
//    addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
//  - Decoded controls for the supported set:
//    mem_size=10 for lw/sw; ext_op=1 for addi/lw/sw.
//    shift_idx=1 for sllv/srlv; shift_dir=1 for srl/srlv; alu_asrc=1 for all four shifts.
//  - ex_reg_write is forced to 0 when ex_wr_addr==0.
//  - Internal registered br_kind in {none, beq, bne, jmp, jreg}.
//    jmp = j/jal, jreg = jr/jalr.
//  - taken = ex_valid & (beq&ex_zero | bne&~ex_zero | jmp | jreg).
//  - npc_op = 01 for a taken beq/bne, 10 for jmp, 11 for jreg, else 00.
//  - flush_o = taken.
//  - hazard = ex_valid & ex_mem_read & ex_wr_addr!=0 & id_valid &
//      ((uses_rs & rs==ex_wr_addr) | (uses_rt & rt==ex_wr_addr)).
//    uses_rt holds for R-type ALU ops, beq, bne, sw, sll, srl.
//  - stall_o = hazard & ~flush_o. A flush takes priority because the ID instruction is wrong-path.
//  - ID/EX next-state priority: reset > flush > stall > (id_valid ? decode : bubble).
//    A bubble is all controls 0, with ex_valid=0.
//  - Illegal instruction: ex_valid=1, ex_illegal=1, all write/mem/branch controls 0.
//  - stall_cnt +1 per cycle with stall_o=1; flush_cnt +1 per cycle with flush_o=1.
//    Both saturate at 2^CNT_W-1 with no wrap.
// CONFIGURATION
//  PIPE_CTRL_SUBWORD_EN defined:
//    lb/lbu/lh/lhu/sb/sh decode with ext_op=1.
//    mem_size is 00 for byte and 01 for half; ex_mem_unsigned=1 for lbu/lhu.
//    The loads count as mem_read for hazard detection.
//  Undefined: those six opcodes decode as illegal; ex_mem_unsigned is tied to 0.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//    opcode/funct localparams.
//    ALUOp encodings: ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, LUI 1100, NOR 1110, NONE 0000.
//    NPC_* encodings, br_kind enum, mem_size codes.
//  Sub-module ctrl_decode: purely combinational decoder (instr -> control bundle, uses_rs/rt).
//  This module holds only the ID/EX register, hazard/flush logic and counters.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with id_valid=1 and add -> all ex_*=0, counters=0, npc_op=00.
//  2. add $3,$1,$2 (0x00221820) ->
//     next cycle ex_valid=1, ex_reg_write=1, ex_wr_addr=3, ex_alu_op=0001, ex_alu_src=0.
//  3. lw $5,0($1) (0x8C250000), then add $6,$5,$2 (0x00A23020) ->
//     stall_o=1 for exactly 1 cycle, bubble in EX, stall_cnt=1; add issues one cycle later.
//  4. beq $1,$2 in EX with ex_zero=1 -> npc_op=01, flush_o=1, next ex_valid=0, flush_cnt=1.
//     Same case with ex_zero=0 -> npc_op=00, flush_o=0.
//  5. jal 0x10 (0x0C000010) -> ex_wr_addr=31, ex_call=1, npc_op=10 and flush_o=1 in its EX cycle.
//     Any concurrent hazard does not assert stall_o.
//  6. lbu $4,0($1) (0x90240000): with the macro -> ex_mem_size=00, ex_mem_unsigned=1, ex_mem_read=1.
//     Without the macro -> ex_illegal=1, ex_reg_write=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs, ALU ops,
// NPC selects, branch kinds, memory sizes and the decoded control bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b1110;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_JMP  = 3'd3,
    BR_JREG = 3'd4
  } br_kind_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       ext_op;
    logic       alu_asrc;
    logic       shift_idx;
    logic       shift_dir;
    logic       call;
    logic       illegal;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    logic [3:0] alu_op;
    br_kind_e   br_kind;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: 32-bit MIPS word -> control bundle,
// destination register and source-usage flags. Sub-word memory ops need PIPE_CTRL_SUBWORD_EN.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic [31:0]       instr,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] wr_addr,
  output logic              uses_rs,
  output logic              uses_rt
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              legal;
  logic              r_op;
  logic              r_shamt;
  logic              unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rt           = REG_AW'(instr[20:16]);
  assign rd           = REG_AW'(instr[15:11]);
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    ctrl         = '0;
    ctrl.br_kind = BR_NONE;
    wr_addr      = '0;
    uses_rs      = 1'b0;
    uses_rt      = 1'b0;
    legal        = 1'b1;
    r_op         = 1'b0;
    r_shamt      = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin ctrl.alu_op = ALU_ADD;  r_op = 1'b1; end
          F_SUB, F_SUBU: begin ctrl.alu_op = ALU_SUB;  r_op = 1'b1; end
          F_AND:         begin ctrl.alu_op = ALU_AND;  r_op = 1'b1; end
          F_OR:          begin ctrl.alu_op = ALU_OR;   r_op = 1'b1; end
          F_NOR:         begin ctrl.alu_op = ALU_NOR;  r_op = 1'b1; end
          F_SLT:         begin ctrl.alu_op = ALU_SLT;  r_op = 1'b1; end
          F_SLTU:        begin ctrl.alu_op = ALU_SLTU; r_op = 1'b1; end
          F_SLL:  begin ctrl.alu_asrc = 1'b1; r_shamt = 1'b1; end
          F_SRL:  begin ctrl.alu_asrc = 1'b1; ctrl.shift_dir = 1'b1; r_shamt = 1'b1; end
          F_SLLV: begin ctrl.alu_asrc = 1'b1; ctrl.shift_idx = 1'b1; r_op = 1'b1; end
          F_SRLV: begin
            ctrl.alu_asrc  = 1'b1;
            ctrl.shift_idx = 1'b1;
            ctrl.shift_dir = 1'b1;
            r_op           = 1'b1;
          end
          F_JR: begin ctrl.br_kind = BR_JREG; uses_rs = 1'b1; end
          F_JALR: begin
            ctrl.br_kind   = BR_JREG;
            ctrl.call      = 1'b1;
            ctrl.reg_write = 1'b1;
            wr_addr        = rd;
            uses_rs        = 1'b1;
          end
          default: legal = 1'b0;
        endcase
        // Constant shifts read only rt; the variable shifts take the amount from rs.
        if (r_op) begin
          ctrl.reg_write = 1'b1;
          wr_addr        = rd;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
        if (r_shamt) begin
          ctrl.reg_write = 1'b1;
          wr_addr        = rd;
          uses_rt        = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        wr_addr        = rt;
        uses_rs        = (opcode != OP_LUI);
        ctrl.ext_op    = (opcode == OP_ADDI);
        case (opcode)
          OP_ADDI: ctrl.alu_op = ALU_ADD;
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_LUI;
        endcase
      end
      OP_LW: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.mem_size = MEM_WORD; wr_addr = rt; uses_rs = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1;
        ctrl.mem_write = 1'b1; ctrl.mem_size = MEM_WORD;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
`ifdef PIPE_CTRL_SUBWORD_EN
      OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.mem_size     = (opcode == OP_LB || opcode == OP_LBU) ? MEM_BYTE : MEM_HALF;
        ctrl.mem_unsigned = (opcode == OP_LBU || opcode == OP_LHU);
        wr_addr = rt; uses_rs = 1'b1;
      end
      OP_SB, OP_SH: begin
        ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_size  = (opcode == OP_SB) ? MEM_BYTE : MEM_HALF;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
`endif
      OP_BEQ, OP_BNE: begin
        ctrl.br_kind = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
        ctrl.alu_op  = ALU_SUB;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_J: ctrl.br_kind = BR_JMP;
      OP_JAL: begin
        ctrl.br_kind   = BR_JMP;
        ctrl.call      = 1'b1;
        ctrl.reg_write = 1'b1;
        wr_addr        = REG_AW'(LINK_REG);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.br_kind = BR_NONE;
      ctrl.illegal = 1'b1;
      wr_addr      = '0;
      uses_rs      = 1'b0;
      uses_rt      = 1'b0;
    end
    if (wr_addr == '0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: ID/EX control register, load-use stall, EX-stage branch/jump
// resolution and saturating stall/flush counters. Optional sub-word ops: PIPE_CTRL_SUBWORD_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 4,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic               ex_zero,
  output logic               stall_o,
  output logic               flush_o,
  output logic [1:0]         npc_op,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_ext_op,
  output logic               ex_alu_asrc,
  output logic               ex_shift_idx,
  output logic               ex_shift_dir,
  output logic               ex_call,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]  ex_wr_addr,
  output logic               ex_illegal,
  output logic [1:0]         ex_mem_size,
  output logic               ex_mem_unsigned,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_wr_addr;
  logic              dec_uses_rs;
  logic              dec_uses_rt;

  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              taken;
  logic              hazard;

  ctrl_decode #(
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .instr   (id_instr),
    .ctrl    (dec_ctrl),
    .wr_addr (dec_wr_addr),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  assign id_rs = REG_AW'(id_instr[25:21]);
  assign id_rt = REG_AW'(id_instr[20:16]);

  always_comb begin
    taken  = 1'b0;
    npc_op = NPC_PC4;
    if (valid_q) begin
      case (ctrl_q.br_kind)
        BR_BEQ:  if (ex_zero)  begin taken = 1'b1; npc_op = NPC_BR; end
        BR_BNE:  if (!ex_zero) begin taken = 1'b1; npc_op = NPC_BR; end
        BR_JMP:  begin taken = 1'b1; npc_op = NPC_J;   end
        BR_JREG: begin taken = 1'b1; npc_op = NPC_REG; end
        default: ;
      endcase
    end
  end

  assign flush_o = taken;
  assign hazard  = valid_q && ctrl_q.mem_read && (wr_addr_q != '0) && id_valid &&
                   ((dec_uses_rs && (id_rs == wr_addr_q)) ||
                    (dec_uses_rt && (id_rt == wr_addr_q)));
  // The ID instruction is wrong-path whenever EX redirects, so never stall on it.
  assign stall_o = hazard && !flush_o;

  always_comb begin
    ctrl_d         = '0;
    ctrl_d.br_kind = BR_NONE;
    valid_d        = 1'b0;
    wr_addr_d      = '0;
    if (!flush_o && !stall_o && id_valid) begin
      ctrl_d    = dec_ctrl;
      valid_d   = 1'b1;
      wr_addr_d = dec_wr_addr;
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q         <= '0;
      valid_q        <= 1'b0;
      wr_addr_q      <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ctrl_q         <= ctrl_d;
      valid_q        <= valid_d;
      wr_addr_q      <= wr_addr_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign ex_valid        = valid_q;
  assign ex_reg_write    = ctrl_q.reg_write;
  assign ex_mem_read     = ctrl_q.mem_read;
  assign ex_mem_write    = ctrl_q.mem_write;
  assign ex_mem_to_reg   = ctrl_q.mem_to_reg;
  assign ex_alu_src      = ctrl_q.alu_src;
  assign ex_ext_op       = ctrl_q.ext_op;
  assign ex_alu_asrc     = ctrl_q.alu_asrc;
  assign ex_shift_idx    = ctrl_q.shift_idx;
  assign ex_shift_dir    = ctrl_q.shift_dir;
  assign ex_call         = ctrl_q.call;
  assign ex_alu_op       = ALUOP_W'(ctrl_q.alu_op);
  assign ex_wr_addr      = wr_addr_q;
  assign ex_illegal      = ctrl_q.illegal;
  assign ex_mem_size     = ctrl_q.mem_size;
  assign ex_mem_unsigned = ctrl_q.mem_unsigned;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; narrow counters exercise saturation.
// Define PIPE_CTRL_SUBWORD_EN for both bench and RTL to check the sub-word loads.
module tb_pipe_ctrl_unit;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic             ex_zero;
  logic             stall_o, flush_o;
  logic [1:0]       npc_op;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic             ex_alu_src, ex_ext_op, ex_alu_asrc, ex_shift_idx, ex_shift_dir, ex_call;
  logic [3:0]       ex_alu_op;
  logic [4:0]       ex_wr_addr;
  logic             ex_illegal;
  logic [1:0]       ex_mem_size;
  logic             ex_mem_unsigned;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADD    = 32'h00221820; // add  $3,$1,$2
  localparam logic [31:0] I_LW     = 32'h8C250000; // lw   $5,0($1)
  localparam logic [31:0] I_ADD_U5 = 32'h00A23020; // add  $6,$5,$2
  localparam logic [31:0] I_LUI5   = 32'h3C050001; // lui  $5,1
  localparam logic [31:0] I_BEQ    = 32'h10220004; // beq  $1,$2,4
  localparam logic [31:0] I_BNE    = 32'h14220004; // bne  $1,$2,4
  localparam logic [31:0] I_JAL    = 32'h0C000010; // jal  0x10
  localparam logic [31:0] I_ADD_31 = 32'h03E23020; // add  $6,$31,$2
  localparam logic [31:0] I_JR     = 32'h03E00008; // jr   $31
  localparam logic [31:0] I_J      = 32'h08000000; // j    0
  localparam logic [31:0] I_SRLV   = 32'h00623806; // srlv $7,$2,$3
  localparam logic [31:0] I_ADD_R0 = 32'h00220020; // add  $0,$1,$2
  localparam logic [31:0] I_LBU    = 32'h90240000; // lbu  $4,0($1)
  localparam logic [31:0] I_BAD    = 32'hFC000000;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .LINK_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .ex_zero(ex_zero),
    .stall_o(stall_o), .flush_o(flush_o), .npc_op(npc_op), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_ext_op(ex_ext_op),
    .ex_alu_asrc(ex_alu_asrc), .ex_shift_idx(ex_shift_idx), .ex_shift_dir(ex_shift_dir),
    .ex_call(ex_call), .ex_alu_op(ex_alu_op), .ex_wr_addr(ex_wr_addr), .ex_illegal(ex_illegal),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    id_instr = instr;
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b1; id_instr = I_ADD; ex_zero = 1'b0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got=%0h exp=0", ex_reg_write); end
    checks++; if (ex_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got=%0h exp=0", ex_wr_addr); end
    checks++; if (ex_alu_op !== 4'd0) begin errors++; $display("FAIL reset_alu_op got=%0h exp=0", ex_alu_op); end
    checks++; if ({stall_cnt, flush_cnt} !== '0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    checks++; if ({npc_op, stall_o, flush_o} !== 4'b0) begin errors++; $display("FAIL reset_comb npc=%0h stall=%0h flush=%0h exp=0", npc_op, stall_o, flush_o); end
    $display("reset: ex_valid=%0h counters=%0d/%0d", ex_valid, stall_cnt, flush_cnt);
    rst_n = 1'b1; id_valid = 1'b0;
  endtask

  task automatic test_add();
    issue(I_ADD);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0h exp=1", ex_valid); end
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_reg_write got=%0h exp=1", ex_reg_write); end
    checks++; if (ex_wr_addr !== 5'd3) begin errors++; $display("FAIL add_wr_addr got=%0d exp=3", ex_wr_addr); end
    checks++; if (ex_alu_op !== 4'b0001) begin errors++; $display("FAIL add_alu_op got=%0h exp=1", ex_alu_op); end
    checks++; if ({ex_alu_src, ex_illegal, ex_mem_read} !== 3'b000) begin errors++; $display("FAIL add_misc got=%0b exp=000", {ex_alu_src, ex_illegal, ex_mem_read}); end
    $display("add: wr=%0d alu_op=%0h", ex_wr_addr, ex_alu_op);
  endtask

  task automatic test_load_use();
    issue(I_LW);
    checks++; if ({ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_ext_op} !== 4'b1111) begin errors++; $display("FAIL lw_ctrl got=%0b exp=1111", {ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_ext_op}); end
    checks++; if ({ex_mem_size, ex_wr_addr, ex_alu_op} !== {2'b10, 5'd5, 4'b0001}) begin errors++; $display("FAIL lw_fields size=%0b wr=%0d alu=%0h exp=10/5/1", ex_mem_size, ex_wr_addr, ex_alu_op); end
    id_instr = I_ADD_U5; id_valid = 1'b1; #1;
    checks++; if ({stall_o, flush_o} !== 2'b10) begin errors++; $display("FAIL lu_stall stall=%0h flush=%0h exp=1/0", stall_o, flush_o); end
    tick();
    checks++; if ({ex_valid, stall_o} !== 2'b00) begin errors++; $display("FAIL lu_bubble valid=%0h stall=%0h exp=0/0", ex_valid, stall_o); end
    checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    tick(); id_valid = 1'b0;
    checks++; if ({ex_valid, ex_wr_addr} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_issue valid=%0h wr=%0d exp=1/6", ex_valid, ex_wr_addr); end
    $display("load_use: stall_cnt=%0d ex_wr_addr=%0d", stall_cnt, ex_wr_addr);
    // A load followed by an instruction that reads no register must not stall.
    issue(I_LW);
    id_instr = I_LUI5; id_valid = 1'b1; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_no_use got=%0h exp=0", stall_o); end
    tick(); id_valid = 1'b0;
    checks++; if ({ex_valid, ex_alu_op, stall_cnt} !== {1'b1, 4'b1100, 3'd1}) begin errors++; $display("FAIL lui_issue valid=%0h alu=%0h cnt=%0d exp=1/c/1", ex_valid, ex_alu_op, stall_cnt); end
  endtask

  task automatic test_branch();
    issue(I_BEQ);
    ex_zero = 1'b1; id_instr = I_ADD; id_valid = 1'b1; #1;
    checks++; if ({npc_op, flush_o, stall_o} !== 4'b0110) begin errors++; $display("FAIL beq_taken npc=%0b flush=%0h stall=%0h exp=01/1/0", npc_op, flush_o, stall_o); end
    tick(); id_valid = 1'b0;
    checks++; if ({ex_valid, flush_cnt} !== {1'b0, 3'd1}) begin errors++; $display("FAIL beq_flush valid=%0h cnt=%0d exp=0/1", ex_valid, flush_cnt); end
    issue(I_BEQ);
    ex_zero = 1'b0; id_instr = I_ADD; id_valid = 1'b1; #1;
    checks++; if ({npc_op, flush_o} !== 3'b000) begin errors++; $display("FAIL beq_not_taken npc=%0b flush=%0h exp=00/0", npc_op, flush_o); end
    tick(); id_valid = 1'b0;
    checks++; if ({ex_valid, flush_cnt} !== {1'b1, 3'd1}) begin errors++; $display("FAIL beq_fall valid=%0h cnt=%0d exp=1/1", ex_valid, flush_cnt); end
    issue(I_BNE);
    ex_zero = 1'b0; #1;
    checks++; if ({npc_op, flush_o} !== 3'b011) begin errors++; $display("FAIL bne_taken npc=%0b flush=%0h exp=01/1", npc_op, flush_o); end
    tick();
    $display("branch: flush_cnt=%0d", flush_cnt);
  endtask

  task automatic test_jumps();
    issue(I_JAL);
    id_instr = I_ADD_31; id_valid = 1'b1; #1;
    checks++; if ({ex_wr_addr, ex_call, ex_reg_write} !== {5'd31, 1'b1, 1'b1}) begin errors++; $display("FAIL jal_link wr=%0d call=%0h rw=%0h exp=31/1/1", ex_wr_addr, ex_call, ex_reg_write); end
    checks++; if ({npc_op, flush_o, stall_o} !== 4'b1010) begin errors++; $display("FAIL jal_redirect npc=%0b flush=%0h stall=%0h exp=10/1/0", npc_op, flush_o, stall_o); end
    tick(); id_valid = 1'b0;
    checks++; if ({ex_valid, flush_cnt} !== {1'b0, 3'd3}) begin errors++; $display("FAIL jal_flush valid=%0h cnt=%0d exp=0/3", ex_valid, flush_cnt); end
    issue(I_JR);
    checks++; if ({npc_op, flush_o, ex_reg_write} !== 4'b1110) begin errors++; $display("FAIL jr npc=%0b flush=%0h rw=%0h exp=11/1/0", npc_op, flush_o, ex_reg_write); end
    tick();
    $display("jumps: flush_cnt=%0d", flush_cnt);
  endtask

  task automatic test_decode_misc();
    issue(I_SRLV);
    checks++; if ({ex_alu_asrc, ex_shift_idx, ex_shift_dir, ex_wr_addr} !== {3'b111, 5'd7}) begin errors++; $display("FAIL srlv asrc/idx/dir=%0b wr=%0d exp=111/7", {ex_alu_asrc, ex_shift_idx, ex_shift_dir}, ex_wr_addr); end
    issue(I_ADD_R0);
    checks++; if ({ex_valid, ex_reg_write} !== 2'b10) begin errors++; $display("FAIL reg0_write valid=%0h rw=%0h exp=1/0", ex_valid, ex_reg_write); end
    issue(I_BAD);
    checks++; if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, flush_o} !== 6'b110000) begin errors++; $display("FAIL illegal got=%0b exp=110000", {ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, flush_o}); end
    issue(I_LBU);
`ifdef PIPE_CTRL_SUBWORD_EN
    checks++; if ({ex_mem_size, ex_mem_unsigned, ex_mem_read, ex_illegal, ex_wr_addr} !== {2'b00, 1'b1, 1'b1, 1'b0, 5'd4}) begin errors++; $display("FAIL lbu size=%0b uns=%0h rd=%0h ill=%0h wr=%0d exp=00/1/1/0/4", ex_mem_size, ex_mem_unsigned, ex_mem_read, ex_illegal, ex_wr_addr); end
`else
    checks++; if ({ex_illegal, ex_reg_write, ex_mem_read, ex_mem_unsigned} !== 4'b1000) begin errors++; $display("FAIL lbu_illegal ill=%0h rw=%0h rd=%0h uns=%0h exp=1/0/0/0", ex_illegal, ex_reg_write, ex_mem_read, ex_mem_unsigned); end
`endif
    $display("decode_misc: lbu illegal=%0h mem_size=%0b", ex_illegal, ex_mem_size);
  endtask

  task automatic test_saturation();
    id_instr = I_J; id_valid = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    id_valid = 1'b0;
    tick(); tick();
    checks++; if (flush_cnt !== 3'd7) begin errors++; $display("FAIL flush_saturate got=%0d exp=7", flush_cnt); end
    checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL stall_hold got=%0d exp=1", stall_cnt); end
    $display("saturation: flush_cnt=%0d", flush_cnt);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_branch();
    test_jumps();
    test_decode_misc();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
